arb_rr: RTL

ARB_RR -- requirements
Module: arb_rr

---
 rtl/arb_rr_if.sv | 32 +++
 rtl/arb_rr.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/arb_rr_if.sv
// Request/grant bundle between a set of requesters plus the downstream
// consumer and the round-robin / fixed-priority arbiter.
interface arb_rr_if #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
);

  logic [N-1:0]  request;
  logic          ready;
  logic [N-1:0]  grant;
  logic          valid;
  logic [IW-1:0] grant_id;

  // Requesters and downstream side: drive requests and acceptance
  modport master (
    output request,
    output ready,
    input  grant,
    input  valid,
    input  grant_id
  );

  // Arbiter side: observe requests, present the registered winner
  modport slave (
    input  request,
    input  ready,
    output grant,
    output valid,
    output grant_id
  );

endinterface

// File: rtl/arb_rr.sv
// N-way arbiter with registered one-hot grant and binary grant index.
// MODE=0 gives fixed priority (lowest index wins); MODE=1 gives round-robin
// starting from a pointer that moves past each completed winner.
// A grant is held without preemption until the downstream accepts it, and
// acceptance re-arbitrates on the same edge so back-to-back grants have no
// bubble.
module arb_rr #(
  parameter int N    = 8,
  parameter int MODE = 1,
  parameter int IW   = $clog2(N)
) (
  input  logic     clk,
  input  logic     nreset,
  arb_rr_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } ArbState;

  ArbState       r_state;
  logic [N-1:0]  r_grant;
  logic          r_valid;
  logic [IW-1:0] r_grantId;
  logic [IW-1:0] r_ptr;

  ArbState       w_nextState;
  logic [N-1:0]  w_nextGrant;
  logic          w_nextValid;
  logic [IW-1:0] w_nextId;
  logic [IW-1:0] w_nextPtr;

  logic [IW-1:0] w_ptrAfter;
  logic [IW-1:0] w_base;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [N-1:0]  w_winnerGrant;

  // Pointer value once the current grant completes: one past the winner, wrapping
  assign w_ptrAfter = (r_grantId == IW'(N - 1)) ? '0 : r_grantId + IW'(1);

  // Search start: the completing winner's successor on a transfer edge, else the stored pointer
  always_comb begin
    w_base = '0;
    if (MODE == 1) begin
      if (r_state == GRANTED) begin
        w_base = w_ptrAfter;
      end else begin
        w_base = r_ptr;
      end
    end
  end

  // Find the first asserted request at or above w_base, wrapping past N-1 back to 0
  always_comb begin
    w_found       = 1'b0;
    w_winner      = '0;
    w_winnerGrant = '0;
    w_sum         = '0;
    w_idx         = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, w_base} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_idx = w_sum[IW-1:0];
      if (!w_found && bus.request[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    if (w_found) begin
      w_winnerGrant[w_winner] = 1'b1;
    end
  end

  // Next-state and next-output decision for the IDLE/GRANTED machine
  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextValid = r_valid;
    w_nextId    = r_grantId;
    w_nextPtr   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextState = GRANTED;
          w_nextGrant = w_winnerGrant;
          w_nextValid = 1'b1;
          w_nextId    = w_winner;
        end
      end
      GRANTED: begin
        if (bus.ready) begin
          if (MODE == 1) begin
            w_nextPtr = w_ptrAfter;
          end
          if (w_found) begin
            w_nextGrant = w_winnerGrant;
            w_nextValid = 1'b1;
            w_nextId    = w_winner;
          end else begin
            w_nextState = IDLE;
            w_nextGrant = '0;
            w_nextValid = 1'b0;
            w_nextId    = '0;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextGrant = '0;
        w_nextValid = 1'b0;
        w_nextId    = '0;
      end
    endcase
  end

  // State, output and pointer registers; reset drops any grant immediately
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_grantId <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_grant   <= w_nextGrant;
      r_valid   <= w_nextValid;
      r_grantId <= w_nextId;
      r_ptr     <= w_nextPtr;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.valid    = r_valid;
  assign bus.grant_id = r_grantId;

endmodule
